// File: rtl/road_fighter_pkg.sv
// Shared road-fighter types: the five-word car state vector, its field
// indices, screen limits and the crash monitor state encoding.
package road_fighter_pkg;

  localparam int unsigned COORD_W  = 11;
  localparam int unsigned SUM_W    = 12;
  localparam int unsigned IMG_ID   = 0;
  localparam int unsigned X        = 1;
  localparam int unsigned Y        = 2;
  localparam int unsigned W        = 3;
  localparam int unsigned H        = 4;
  localparam int unsigned SCREEN_H = 480;

  typedef logic [0:4][0:COORD_W-1] car_state_t;

  typedef enum logic [1:0] {
    RUN,
    CHECK,
    CRASH,
    RECOVER
  } crash_state_t;

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned bounding-box overlap test between two cars.
// Sums are one bit wider than the coordinates so x+w never wraps.
module box_overlap
  import road_fighter_pkg::*;
(
  input  car_state_t a,
  input  car_state_t b,
  output logic       overlap
);

  logic [SUM_W-1:0] ax, ay, aw, ah;
  logic [SUM_W-1:0] bx, by, bw, bh;
  logic             unused_img;

  always_comb begin
    ax = SUM_W'(a[X]);
    ay = SUM_W'(a[Y]);
    aw = SUM_W'(a[W]);
    ah = SUM_W'(a[H]);
    bx = SUM_W'(b[X]);
    by = SUM_W'(b[Y]);
    bw = SUM_W'(b[W]);
    bh = SUM_W'(b[H]);
    // strict compares: shared edges do not count as a collision
    overlap = (ax < bx + bw) && (bx < ax + aw) &&
              (ay < by + bh) && (by < ay + ah);
  end

  // image ids play no part in geometry
  assign unused_img = ^{a[IMG_ID], b[IMG_ID]};

endmodule

// File: rtl/car_crash_monitor.sv
// Per-frame collision sweep of the player against the AI cars, followed by a
// frame-counted crash and invulnerability sequence on the first hit.
module car_crash_monitor
  import road_fighter_pkg::*;
#(
  parameter int unsigned NUM_CARS     = 4,
  parameter int unsigned CRASH_FRAMES = 60,
  parameter int unsigned GRACE_FRAMES = 90
) (
  input  logic                             clk,
  input  logic                             resetN,
  input  logic                             frame_start,
  input  logic [0:4][0:10]                 player_state,
  input  logic [0:NUM_CARS-1][0:4][0:10]   ai_car_states,
  output logic                             crash_active,
  output logic                             invulnerable,
  output logic [2:0]                       hit_car_idx,
  output logic [7:0]                       crash_count,
  output logic                             check_done
);

  localparam int unsigned MAX_FRAMES = (CRASH_FRAMES > GRACE_FRAMES) ? CRASH_FRAMES : GRACE_FRAMES;
  localparam int unsigned CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam logic [2:0]  LAST_IDX   = 3'(NUM_CARS - 1);

  crash_state_t                state_q, state_d;
  logic [2:0]                  idx_q, idx_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  car_state_t                  snap_player_q, snap_player_d;
  car_state_t [0:NUM_CARS-1]   snap_cars_q, snap_cars_d;
  logic                        crash_active_q, crash_active_d;
  logic                        invulnerable_q, invulnerable_d;
  logic [2:0]                  hit_car_idx_q, hit_car_idx_d;
  logic [7:0]                  crash_count_q, crash_count_d;
  logic                        check_done_q, check_done_d;

  car_state_t                  cur_car;
  logic                        overlap;
  logic                        skip;

  always_comb begin
    cur_car = '0;
    for (int unsigned i = 0; i < NUM_CARS; i++) begin
      if (idx_q == 3'(i)) cur_car = snap_cars_q[i];
    end
    skip = (cur_car[IMG_ID] == '0) || (cur_car[Y] >= COORD_W'(SCREEN_H));
  end

  box_overlap u_box_overlap (
    .a       (snap_player_q),
    .b       (cur_car),
    .overlap (overlap)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    snap_player_d  = snap_player_q;
    snap_cars_d    = snap_cars_q;
    hit_car_idx_d  = hit_car_idx_q;
    crash_count_d  = crash_count_q;
    check_done_d   = 1'b0;

    case (state_q)
      RUN: begin
        if (frame_start) begin
          snap_player_d = player_state;
          snap_cars_d   = ai_car_states;
          idx_d         = '0;
          state_d       = CHECK;
        end
      end
      CHECK: begin
        if (!skip && overlap) begin
          hit_car_idx_d = idx_q;
          if (crash_count_q != 8'hFF) crash_count_d = crash_count_q + 8'd1;
          cnt_d        = CNT_W'(CRASH_FRAMES - 1);
          check_done_d = 1'b1;
          state_d      = CRASH;
        end else if (idx_q == LAST_IDX) begin
          check_done_d = 1'b1;
          state_d      = RUN;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      CRASH: begin
        if (frame_start) begin
          if (cnt_q == '0) begin
            cnt_d   = CNT_W'(GRACE_FRAMES - 1);
            state_d = RECOVER;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      RECOVER: begin
        if (frame_start) begin
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    // status flags follow the state being entered so they stay registered
    crash_active_d = (state_d == CRASH);
    invulnerable_d = (state_d == RECOVER);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q        <= RUN;
      idx_q          <= '0;
      cnt_q          <= '0;
      snap_player_q  <= '0;
      snap_cars_q    <= '0;
      crash_active_q <= 1'b0;
      invulnerable_q <= 1'b0;
      hit_car_idx_q  <= '0;
      crash_count_q  <= '0;
      check_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      snap_player_q  <= snap_player_d;
      snap_cars_q    <= snap_cars_d;
      crash_active_q <= crash_active_d;
      invulnerable_q <= invulnerable_d;
      hit_car_idx_q  <= hit_car_idx_d;
      crash_count_q  <= crash_count_d;
      check_done_q   <= check_done_d;
    end
  end

  assign crash_active = crash_active_q;
  assign invulnerable = invulnerable_q;
  assign hit_car_idx  = hit_car_idx_q;
  assign crash_count  = crash_count_q;
  assign check_done   = check_done_q;

endmodule
